// File: rtl/cnn_pkg.sv
// cnn_pkg: layer codes, pool-layer test and PCIe loader state encoding
// shared by the AlexNet controller and its PCIe layer loader.
package cnn_pkg;

    typedef enum logic [3:0] {
        LYR_IDLE  = 4'd0,
        LYR_CONV1 = 4'd1,
        LYR_POOL1 = 4'd2,
        LYR_CONV2 = 4'd3,
        LYR_POOL2 = 4'd4,
        LYR_CONV3 = 4'd5,
        LYR_CONV4 = 4'd6,
        LYR_CONV5 = 4'd7,
        LYR_POOL5 = 4'd8,
        LYR_FC6   = 4'd9,
        LYR_FC7   = 4'd10,
        LYR_FC8   = 4'd11
    } layer_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_B,
        S_HDR_W,
        S_HDR_L,
        S_LD_B,
        S_LD_W,
        S_LD_L,
        S_DONE,
        S_ERR
    } ld_state_e;

    function automatic logic is_pool_layer(input logic [3:0] l);
        return l == LYR_POOL1 || l == LYR_POOL2 || l == LYR_POOL5;
    endfunction

endpackage

// File: rtl/section_counter.sv
// section_counter: per-section beat index with reload and last-beat flag;
// a reload always wins over an increment so sections chain without bubbles.
module section_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] count_i,
    input  logic         inc_i,
    output logic [W-1:0] idx_o,
    output logic         last_o
);

    logic [W-1:0] lim_q, idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lim_q <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            lim_q <= count_i;
            idx_q <= '0;
        end else if (inc_i) begin
            idx_q <= idx_q + W'(1);
        end
    end

    assign idx_o  = idx_q;
    assign last_o = idx_q == lim_q - W'(1);

endmodule

// File: rtl/pcie_layer_loader.sv
// pcie_layer_loader: parses a nb/nw/nl header from the PCIe stream and
// routes the payload into the bias, weight and layer-data RAMs.
module pcie_layer_loader
    import cnn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [3:0]        layer,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bias_we,
    output logic              weight_we,
    output logic              layer_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              data_ready,
    output logic              error
);

    localparam int CW = DATA_W > ADDR_W ? DATA_W + 1 : ADDR_W + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(1) << ADDR_W;

    ld_state_e         state_q, state_d;
    logic [DATA_W-1:0] nb_q, nb_d, nw_q, nw_d, nl_q, nl_d;
    logic              bias_we_q, bias_we_d, weight_we_q, weight_we_d, layer_we_q, layer_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_q, ready_d, error_q, error_d;
    logic              beat, hdr_bad, cnt_load, cnt_inc, last;
    logic [DATA_W-1:0] cnt_val, idx;

    function automatic ld_state_e first_sec(input logic [DATA_W-1:0] b, w, l);
        if (b != '0) return S_LD_B;
        if (w != '0) return S_LD_W;
        if (l != '0) return S_LD_L;
        return S_DONE;
    endfunction

    function automatic logic too_big(input logic [DATA_W-1:0] c);
        return CW'(c) > CNT_MAX;
    endfunction

    assign s_ready = load_req && state_q inside {S_HDR_B, S_HDR_W, S_HDR_L, S_LD_B, S_LD_W, S_LD_L};
    assign beat    = s_valid && s_ready;
    // nl is still on the bus when the HDR_L beat is checked
    assign hdr_bad = layer == LYR_IDLE
                  || (is_pool_layer(layer) && (nb_q != '0 || nw_q != '0))
                  || too_big(nb_q) || too_big(nw_q) || too_big(s_data);

    always_comb begin
        state_d     = state_q;
        nb_d        = nb_q;
        nw_d        = nw_q;
        nl_d        = nl_q;
        bias_we_d   = 1'b0;
        weight_we_d = 1'b0;
        layer_we_d  = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        if (beat && state_q inside {S_LD_B, S_LD_W, S_LD_L}) begin
            addr_d = ADDR_W'(idx);
            data_d = s_data;
        end
        case (state_q)
            S_IDLE:  if (load_req) state_d = S_HDR_B;
            S_HDR_B: if (beat) begin nb_d = s_data; state_d = S_HDR_W; end
            S_HDR_W: if (beat) begin nw_d = s_data; state_d = S_HDR_L; end
            S_HDR_L: if (beat) begin
                nl_d    = s_data;
                state_d = hdr_bad ? S_ERR : first_sec(nb_q, nw_q, s_data);
            end
            S_LD_B: if (beat) begin
                bias_we_d = 1'b1;
                if (last) state_d = first_sec('0, nw_q, nl_q);
            end
            S_LD_W: if (beat) begin
                weight_we_d = 1'b1;
                if (last) state_d = first_sec('0, '0, nl_q);
            end
            S_LD_L: if (beat) begin
                layer_we_d = 1'b1;
                if (last) state_d = S_DONE;
            end
            default: if (!load_req) state_d = S_IDLE;
        endcase
        if (!load_req && state_q != S_IDLE) state_d = S_IDLE;
    end

    assign cnt_load = state_d != state_q && state_d inside {S_LD_B, S_LD_W, S_LD_L};
    assign cnt_val  = state_d == S_LD_B ? nb_d : state_d == S_LD_W ? nw_d : nl_d;
    assign cnt_inc  = beat && state_q inside {S_LD_B, S_LD_W, S_LD_L};
    assign ready_d  = state_q == S_DONE && state_d == S_DONE;
    assign error_d  = state_d == S_ERR;

    section_counter #(.W(DATA_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .count_i(cnt_val),
        .inc_i  (cnt_inc),
        .idx_o  (idx),
        .last_o (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            nb_q        <= '0;
            nw_q        <= '0;
            nl_q        <= '0;
            bias_we_q   <= 1'b0;
            weight_we_q <= 1'b0;
            layer_we_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            nb_q        <= nb_d;
            nw_q        <= nw_d;
            nl_q        <= nl_d;
            bias_we_q   <= bias_we_d;
            weight_we_q <= weight_we_d;
            layer_we_q  <= layer_we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    end

    assign bias_we    = bias_we_q;
    assign weight_we  = weight_we_q;
    assign layer_we   = layer_we_q;
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign data_ready = ready_q;
    assign error      = error_q;

endmodule

// File: tb/tb_pcie_layer_loader.sv
// tb_pcie_layer_loader: directed and randomized loads checked against a
// write-list model built from header counts and payload order.
module tb_pcie_layer_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic [3:0]  layer = 4'd0;
    logic [15:0] s_data = 16'h0;
    logic        s_valid = 1'b0;
    logic        s_ready, bias_we, weight_we, layer_we, data_ready, error;
    logic [15:0] wr_addr, wr_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    pcie_layer_loader dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .layer     (layer),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .bias_we   (bias_we),
        .weight_we (weight_we),
        .layer_we  (layer_we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .data_ready(data_ready),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: full load; mode 1: drop load_req after cut payload beats; mode 2: reset after cut beats
    task automatic run_load(input logic [3:0] lyr, input int nb, input int nw, input int nl,
                            input int pct, input int mode, input int cut);
        logic [15:0] stream[$];
        wr_t         exp_q[$];
        wr_t         e;
        int          cnt[3];
        int          cyc;
        bit          fire, err;
        logic [2:0]  we;
        logic [15:0] d;
        cnt = '{nb, nw, nl};
        err = lyr == 4'd0 || ((lyr == 4'd2 || lyr == 4'd4 || lyr == 4'd8) && (nb != 0 || nw != 0));
        stream.push_back(16'(nb));
        stream.push_back(16'(nw));
        stream.push_back(16'(nl));
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < cnt[s]; i++) begin
                d = 16'($urandom);
                stream.push_back(d);
                exp_q.push_back('{kind: 3'(1 << s), addr: 16'(i), data: d});
            end
        if (err) begin
            while (stream.size() > 3) void'(stream.pop_back());
            exp_q.delete();
        end
        if (mode != 0) begin
            while (stream.size() > 3 + cut) void'(stream.pop_back());
            while (exp_q.size() > cut) void'(exp_q.pop_back());
        end
        layer = lyr;
        load_req = 1'b1;
        cyc = 0;
        while ((stream.size() != 0 || exp_q.size() != 0) && cyc < 3000) begin
            s_valid = stream.size() != 0 && $urandom_range(99) < pct;
            if (stream.size() != 0) s_data = stream[0];
            #1;
            fire = s_valid && s_ready;
            tick();
            cyc++;
            if (fire) void'(stream.pop_front());
            we = {layer_we, weight_we, bias_we};
            if (we != 3'b0) begin
                if (exp_q.size() == 0) chk("extra_wr", 64'(we), 64'h0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr", {29'h0, we, wr_addr, wr_data}, {29'h0, e.kind, e.addr, e.data});
                end
            end
        end
        s_valid = 1'b0;
        if (cyc >= 3000) chk("timeout", 64'(cyc), 64'h0);
        if (mode == 1) begin
            load_req = 1'b0;
            for (int i = 0; i < 6; i++) begin
                s_valid = 1'b1;
                s_data = 16'($urandom);
                tick();
                chk("abort_quiet", {layer_we, weight_we, bias_we, data_ready, s_ready}, 64'h0);
            end
            s_valid = 1'b0;
        end else if (mode == 2) begin
            rst = 1'b1;
            #1;
            chk("rst_async", {s_ready, layer_we, weight_we, bias_we, wr_addr, wr_data, data_ready, error}, 64'h0);
            load_req = 1'b0;
            tick();
            rst = 1'b0;
            tick();
        end else begin
            if (err) begin
                chk("err_hi", {error, data_ready, s_ready}, 64'h4);
            end else begin
                chk("dr_lo", {error, data_ready, s_ready}, 64'h0);
                tick();
                chk("dr_hi", {error, data_ready}, 64'h1);
            end
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("hold", {data_ready, error, s_ready, layer_we, weight_we, bias_we}, {58'h0, !err, err, 4'h0});
            end
            load_req = 1'b0;
            tick();
            chk("release", {data_ready, error, s_ready}, 64'h0);
        end
    endtask

    initial begin
        tick();
        chk("rst_hold", {s_ready, layer_we, weight_we, bias_we, wr_addr, wr_data, data_ready, error}, 64'h0);
        rst = 1'b0;
        tick();
        chk("idle_out", {s_ready, layer_we, weight_we, bias_we, data_ready, error}, 64'h0);
        run_load(4'd1, 4, 8, 16, 100, 0, 0);
        run_load(4'd2, 0, 0, 5, 50, 0, 0);
        run_load(4'd4, 3, 0, 0, 100, 0, 0);
        run_load(4'd11, 0, 0, 0, 100, 0, 0);
        run_load(4'd3, 2, 8, 4, 100, 1, 4);
        run_load(4'd5, 1, 1, 1, 100, 0, 0);
        run_load(4'd9, 3, 6, 2, 70, 2, 6);
        run_load(4'd9, 3, 6, 2, 100, 0, 0);
        run_load(4'd0, 1, 1, 1, 100, 0, 0);
        for (int k = 0; k < 6; k++)
            run_load(4'($urandom_range(11, 1)), $urandom_range(6), $urandom_range(6),
                     $urandom_range(6), $urandom_range(100, 30), 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
